// File: rtl/tx_ds_char_fifo.sv
// tx_ds_char_fifo: FIFO-buffered Data/Strobe character transmitter.
// Characters (normal or link) enter through a valid/ready handshake into a
// FIFO and are serialised as parity, flag, then data bits LSB first.
// Each line bit lasts BIT_DIV+1 TxClk cycles.
// Optional build macro TX_NULL_EN: adds idle_null_i. When the FIFO is empty
// the transmitter then fills idle time with NULL (ESC followed by FCT).
module tx_ds_char_fifo #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned LCHAR_W    = 2,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned BIT_DIV    = 0
) (
   input  logic                        TxClk,
   input  logic                        TxReset,
   input  logic                        valid_i,
   input  logic [DATA_W-1:0]           dat_i,
   input  logic                        lchar_i,
`ifdef TX_NULL_EN
   input  logic                        idle_null_i,
`endif
   output logic                        ready_o,
   output logic                        D_o,
   output logic                        S_o,
   output logic                        busy_o,
   output logic [$clog2(FIFO_DEPTH):0] level_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned DIV_W = 8;
   localparam int unsigned BIT_W = $clog2(DATA_W);
   localparam logic [DATA_W-1:0] LMASK = DATA_W'((32'd1 << LCHAR_W) - 32'd1);

   typedef struct packed {
      logic              lchar;
      logic [DATA_W-1:0] data;
   } char_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PAR,
      ST_FLAG,
      ST_DATA
   } state_t;

   char_t              mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic               ready_q, ready_d;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [DATA_W-1:0]  shift_q, shift_d;
   logic               flag_q, flag_d;
   logic               acc_q, acc_d;
   logic               d_line_q, d_line_d;
   logic               s_line_q, s_line_d;
   logic               busy_q, busy_d;
`ifdef TX_NULL_EN
   logic               nul_pend_q, nul_pend_d;
`endif

   logic               push_c;
   logic               pop_c;
   logic               load_c;
   logic               bit_end_c;
   logic               last_data_c;
   logic               done_c;
   logic               tx_stb_c;
   logic               tx_bit_c;
   char_t              ld_char_c;

   // Character storage; written on accepted pushes only.
   always_ff @(posedge TxClk) begin
      if (!TxReset && push_c) begin
         mem_q[wr_ptr_q] <= char_t'({lchar_i, dat_i});
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge TxClk) begin
      if (TxReset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         ready_q    <= 1'b1;
         state_q    <= ST_IDLE;
         div_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         flag_q     <= 1'b0;
         acc_q      <= 1'b0;
         d_line_q   <= 1'b0;
         s_line_q   <= 1'b0;
         busy_q     <= 1'b0;
`ifdef TX_NULL_EN
         nul_pend_q <= 1'b0;
`endif
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         ready_q    <= ready_d;
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         flag_q     <= flag_d;
         acc_q      <= acc_d;
         d_line_q   <= d_line_d;
         s_line_q   <= s_line_d;
         busy_q     <= busy_d;
`ifdef TX_NULL_EN
         nul_pend_q <= nul_pend_d;
`endif
      end
   end

   // Serializer sequencing, character loading, D/S encoding and FIFO bookkeeping.
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      flag_d      = flag_q;
      acc_d       = acc_q;
      d_line_d    = d_line_q;
      s_line_d    = s_line_q;
      busy_d      = busy_q;
`ifdef TX_NULL_EN
      nul_pend_d  = nul_pend_q;
`endif
      pop_c       = 1'b0;
      load_c      = 1'b0;
      tx_stb_c    = 1'b0;
      tx_bit_c    = 1'b0;
      ld_char_c   = mem_q[rd_ptr_q];
      push_c      = valid_i & ready_q;
      bit_end_c   = (div_q == DIV_W'(BIT_DIV));
      last_data_c = flag_q ? (bit_q == BIT_W'(LCHAR_W - 1))
                           : (bit_q == BIT_W'(DATA_W - 1));

      if (state_q != ST_IDLE) begin
         div_d = bit_end_c ? '0 : div_q + DIV_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
         end
         ST_PAR: begin
            if (bit_end_c) begin
               state_d  = ST_FLAG;
               tx_stb_c = 1'b1;
               tx_bit_c = flag_q;
            end
         end
         ST_FLAG: begin
            if (bit_end_c) begin
               state_d  = ST_DATA;
               bit_d    = '0;
               tx_stb_c = 1'b1;
               tx_bit_c = shift_q[0];
            end
         end
         ST_DATA: begin
            if (bit_end_c) begin
               if (last_data_c) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  bit_d    = bit_q + BIT_W'(1);
                  shift_d  = shift_q >> 1;
                  tx_stb_c = 1'b1;
                  tx_bit_c = shift_q[1];
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // A new character may start from idle or straight after the last data bit.
      done_c = (state_q == ST_IDLE) || ((state_q == ST_DATA) && bit_end_c && last_data_c);

      if (done_c) begin
`ifdef TX_NULL_EN
         // The FCT half of a NULL always goes out before any queued character.
         if (nul_pend_q) begin
            load_c          = 1'b1;
            ld_char_c.lchar = 1'b1;
            ld_char_c.data  = '0;
            nul_pend_d      = 1'b0;
         end else if (level_q != '0) begin
            load_c = 1'b1;
            pop_c  = 1'b1;
         end else if (idle_null_i) begin
            load_c          = 1'b1;
            ld_char_c.lchar = 1'b1;
            ld_char_c.data  = '1;
            nul_pend_d      = 1'b1;
         end
`else
         if (level_q != '0) begin
            load_c = 1'b1;
            pop_c  = 1'b1;
         end
`endif
      end

      if (load_c) begin
         state_d  = ST_PAR;
         div_d    = '0;
         busy_d   = 1'b1;
         flag_d   = ld_char_c.lchar;
         shift_d  = ld_char_c.data;
         // Odd parity over previous character's data plus this flag.
         tx_stb_c = 1'b1;
         tx_bit_c = ~(ld_char_c.lchar ^ acc_q);
         acc_d    = ^(ld_char_c.lchar ? (ld_char_c.data & LMASK) : ld_char_c.data);
      end

      // Strobe toggles when the data line would not change.
      if (tx_stb_c) begin
         d_line_d = tx_bit_c;
         s_line_d = s_line_q ^ (tx_bit_c == d_line_q);
      end

      wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d  = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
      ready_d  = (level_d < LVL_W'(FIFO_DEPTH));
   end

   assign ready_o = ready_q;
   assign D_o     = d_line_q;
   assign S_o     = s_line_q;
   assign busy_o  = busy_q;
   assign level_o = level_q;

endmodule

// File: tb/tb_tx_ds_char_fifo.sv
// tb_tx_ds_char_fifo: two transmitters (BIT_DIV=0 and BIT_DIV=3) share one
// stimulus stream and are compared each cycle against a queue-level model.
module tb_tx_ds_char_fifo;

   localparam int unsigned DW    = 8;
   localparam int unsigned LW    = 2;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned LVLW  = 3;

   logic            TxClk;
   logic            TxReset;
   logic            valid_i;
   logic [DW-1:0]   dat_i;
   logic            lchar_i;
   logic            ready0, d0, s0, busy0;
   logic            ready3, d3, s3, busy3;
   logic [LVLW-1:0] lvl0, lvl3;

   int n_checks;
   int n_errors;

   // Reference model state, index 0 = BIT_DIV 0, index 1 = BIT_DIV 3.
   logic [DW:0] fbuf  [2][16];
   int          fcnt  [2];
   logic        cbits [2][18];
   int          clen  [2];
   int          cidx  [2];
   int          hold  [2];
   logic        macc  [2];
   logic        md    [2];
   logic        ms    [2];
   logic        mtook [2];

   tx_ds_char_fifo #(.DATA_W(DW), .LCHAR_W(LW), .FIFO_DEPTH(DEPTH), .BIT_DIV(0)) u_dut0 (
`ifdef TX_NULL_EN
      .idle_null_i (1'b0),
`endif
      .TxClk   (TxClk),
      .TxReset (TxReset),
      .valid_i (valid_i),
      .dat_i   (dat_i),
      .lchar_i (lchar_i),
      .ready_o (ready0),
      .D_o     (d0),
      .S_o     (s0),
      .busy_o  (busy0),
      .level_o (lvl0)
   );

   tx_ds_char_fifo #(.DATA_W(DW), .LCHAR_W(LW), .FIFO_DEPTH(DEPTH), .BIT_DIV(3)) u_dut3 (
`ifdef TX_NULL_EN
      .idle_null_i (1'b0),
`endif
      .TxClk   (TxClk),
      .TxReset (TxReset),
      .valid_i (valid_i),
      .dat_i   (dat_i),
      .lchar_i (lchar_i),
      .ready_o (ready3),
      .D_o     (d3),
      .S_o     (s3),
      .busy_o  (busy3),
      .level_o (lvl3)
   );

   always #5 TxClk = ~TxClk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock edge of the abstract transmitter: next line bit, pop, push.
   task automatic model_step(input int k, input int div, input logic v,
                             input logic [DW-1:0] dat, input logic lc, input logic rst);
      logic [DW:0] ch;
      int          n;
      logic        b;
      logic        go;
      logic        rdy;
      mtook[k] = 1'b0;
      if (rst) begin
         fcnt[k] = 0; clen[k] = 0; cidx[k] = 0; hold[k] = 0;
         macc[k] = 1'b0; md[k] = 1'b0; ms[k] = 1'b0;
         return;
      end
      rdy = (fcnt[k] < DEPTH);
      go  = 1'b0;
      b   = 1'b0;
      if (hold[k] > 1) begin
         hold[k]--;
      end else if (cidx[k] < clen[k]) begin
         b = cbits[k][cidx[k]];
         cidx[k]++;
         go = 1'b1;
      end else if (fcnt[k] > 0) begin
         ch = fbuf[k][0];
         for (int i = 0; i < 15; i++) fbuf[k][i] = fbuf[k][i+1];
         fcnt[k]--;
         n = ch[DW] ? LW : DW;
         cbits[k][0] = 1'b1 ^ ch[DW] ^ macc[k];
         cbits[k][1] = ch[DW];
         macc[k] = 1'b0;
         for (int i = 0; i < n; i++) begin
            cbits[k][2+i] = ch[i];
            macc[k] = macc[k] ^ ch[i];
         end
         clen[k] = 2 + n;
         b = cbits[k][0];
         cidx[k] = 1;
         go = 1'b1;
      end else begin
         hold[k] = 0;
      end
      if (go) begin
         hold[k] = div + 1;
         ms[k] = (b == md[k]) ? ~ms[k] : ms[k];
         md[k] = b;
      end
      if (v && rdy) begin
         fbuf[k][fcnt[k]] = {lc, dat};
         fcnt[k]++;
         mtook[k] = 1'b1;
      end
   endtask

   task automatic compare_all();
      check_eq("d0_D",     32'(d0),     32'(md[0]));
      check_eq("d0_S",     32'(s0),     32'(ms[0]));
      check_eq("d0_busy",  32'(busy0),  32'(hold[0] > 0));
      check_eq("d0_level", 32'(lvl0),   32'(fcnt[0]));
      check_eq("d0_ready", 32'(ready0), 32'(fcnt[0] < DEPTH));
      check_eq("d3_D",     32'(d3),     32'(md[1]));
      check_eq("d3_S",     32'(s3),     32'(ms[1]));
      check_eq("d3_busy",  32'(busy3),  32'(hold[1] > 0));
      check_eq("d3_level", 32'(lvl3),   32'(fcnt[1]));
      check_eq("d3_ready", 32'(ready3), 32'(fcnt[1] < DEPTH));
   endtask

   // Drive inputs at a falling edge, predict the next rising edge, compare.
   task automatic tick(input logic v, input logic [DW-1:0] dat, input logic lc, input logic rst);
      valid_i = v; dat_i = dat; lchar_i = lc; TxReset = rst;
      model_step(0, 0, v, dat, lc, rst);
      model_step(1, 3, v, dat, lc, rst);
      @(negedge TxClk);
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [9:0]    dseq;
      logic [9:0]    sseq;
      int            bcnt0;
      int            bcnt3;
      int            idx;
      int            guard;
      logic          saw_full;
      logic [DW-1:0] chars [6];

      n_checks = 0;
      n_errors = 0;
      TxClk    = 1'b0;
      TxReset  = 1'b1;
      valid_i  = 1'b0;
      dat_i    = '0;
      lchar_i  = 1'b0;
      @(negedge TxClk);

      // Reset state; a push offered during reset must be ignored.
      tick(1'b0, '0, 1'b0, 1'b1);
      tick(1'b1, 8'h3C, 1'b0, 1'b1);
      tick(1'b0, '0, 1'b0, 1'b1);
      check_eq("rst_D",     32'(d0),     32'd0);
      check_eq("rst_S",     32'(s0),     32'd0);
      check_eq("rst_busy",  32'(busy0),  32'd0);
      check_eq("rst_level", 32'(lvl0),   32'd0);
      check_eq("rst_ready", 32'(ready0), 32'd1);
      idle(2);
      check_eq("rst_push_ignored", 32'(busy0), 32'd0);

      // Single normal character 0xAA.
      tick(1'b1, 8'hAA, 1'b0, 1'b0);
      dseq = '0; sseq = '0; bcnt0 = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, '0, 1'b0, 1'b0);
         dseq = {dseq[8:0], d0};
         sseq = {sseq[8:0], s0};
         if (busy0) bcnt0++;
      end
      check_eq("t1_Dseq", 32'(dseq), 32'(10'b1001010101));
      check_eq("t1_Sseq", 32'(sseq), 32'(10'b0011111111));
      check_eq("t1_busy_len", 32'(bcnt0), 32'd10);
      tick(1'b0, '0, 1'b0, 1'b0);
      check_eq("t1_idle_busy", 32'(busy0), 32'd0);
      check_eq("t1_idle_D", 32'(d0), 32'd1);
      check_eq("t1_idle_S", 32'(s0), 32'd1);
      idle(50);

      // Slow line: 0x0F with each bit held four cycles.
      tick(1'b1, 8'h0F, 1'b0, 1'b0);
      bcnt0 = 0; bcnt3 = 0;
      for (int i = 0; i < 60; i++) begin
         tick(1'b0, '0, 1'b0, 1'b0);
         if (busy0) bcnt0++;
         if (busy3) bcnt3++;
         check_eq("t5_ready3", 32'(ready3), 32'd1);
      end
      check_eq("t5_busy3_len", 32'(bcnt3), 32'd40);
      check_eq("t5_busy0_len", 32'(bcnt0), 32'd10);

      // Back-to-back normal then link character.
      tick(1'b1, 8'hAA, 1'b0, 1'b0);
      tick(1'b1, 8'h01, 1'b1, 1'b0);
      idle(70);

      // Hold valid with six characters into a four-entry FIFO.
      chars[0] = 8'h11; chars[1] = 8'h22; chars[2] = 8'h33;
      chars[3] = 8'h44; chars[4] = 8'h55; chars[5] = 8'h66;
      idx = 0; guard = 0; saw_full = 1'b0;
      while (idx < 6 && guard < 200) begin
         tick(1'b1, chars[idx], 1'b0, 1'b0);
         if (mtook[0]) idx++;
         if (!ready0 && lvl0 == LVLW'(DEPTH)) saw_full = 1'b1;
         guard++;
      end
      check_eq("t3_all_taken", 32'(idx), 32'd6);
      check_eq("t3_saw_full", 32'(saw_full), 32'd1);
      idle(260);

      // Reset in the middle of 0x55, then parity restarts from a clear accumulator.
      tick(1'b1, 8'h55, 1'b0, 1'b0);
      idle(5);
      tick(1'b0, '0, 1'b0, 1'b1);
      check_eq("t4_D", 32'(d0), 32'd0);
      check_eq("t4_S", 32'(s0), 32'd0);
      check_eq("t4_ready", 32'(ready0), 32'd1);
      check_eq("t4_level", 32'(lvl0), 32'd0);
      idle(3);
      check_eq("t4_hold_D", 32'(d0), 32'd0);
      check_eq("t4_hold_S", 32'(s0), 32'd0);
      tick(1'b1, 8'h55, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b0);
      check_eq("t4_parity", 32'(d0), 32'd1);
      idle(60);

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 2500; i++) begin
         tick(1'($urandom_range(0, 9) < 4), DW'($urandom),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 499) == 0));
      end
      idle(300);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
